// File: rtl/mod_add_serial.sv
// -----------------------------------------------------------------------------
// mod_add_serial
//   Nibble-serial modular adder: result = (a + b) mod m for W-bit operands.
//   One 4-bit carry-lookahead slice is reused every cycle. The first pass
//   (ADD) forms the W+1 bit sum {s_hi, s}. The second pass (SUB) forms
//   d = s - m as s + ~m + 1. The final result keeps d when that subtraction
//   did not borrow, and keeps s otherwise. One operation is in flight at a time.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous, active-high reset
//   in_valid   operand set a/b/m valid
//   in_ready   operands accepted (high only in IDLE)
//   a, b       addends, expected < m
//   m          modulus
//   out_valid  result valid (high only in DONE)
//   out_ready  downstream accepts result
//   result     (a + b) mod m, stable while out_valid is high
// -----------------------------------------------------------------------------
module mod_add_serial #(
  parameter int W = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] m,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result
);

  localparam int N     = W / 4;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_SUB  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // 4-bit carry-lookahead slice (CLA_ADD_4): returns {c_out, sum}.
  function automatic logic [4:0] cla_add_4(input logic [3:0] x,
                                           input logic [3:0] y,
                                           input logic       c_in);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = x & y;
    p    = x ^ y;
    c[0] = c_in;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);
    return {c[4], p ^ c[3:0]};
  endfunction

  logic [1:0]       state_q,  state_d;
  logic [IDX_W-1:0] idx_q,    idx_d;
  logic             carry_q,  carry_d;
  logic             s_hi_q,   s_hi_d;
  logic [W-1:0]     s_q,      s_d;
  logic [W-1:0]     d_q,      d_d;
  logic [W-1:0]     result_q, result_d;
  logic [W-1:0]     a_q,      a_d;
  logic [W-1:0]     b_q,      b_d;
  logic [W-1:0]     m_q,      m_d;

  // The single shared slice. ADD feeds it a/b nibbles. SUB feeds it s and ~m nibbles.
  logic [3:0] op_x;
  logic [3:0] op_y;
  logic [4:0] slice_out;
  logic [3:0] slice_sum;
  logic       slice_cout;

  assign op_x       = (state_q == S_SUB) ? s_q[4*idx_q +: 4]  : a_q[4*idx_q +: 4];
  assign op_y       = (state_q == S_SUB) ? ~m_q[4*idx_q +: 4] : b_q[4*idx_q +: 4];
  assign slice_out  = cla_add_4(op_x, op_y, carry_q);
  assign slice_sum  = slice_out[3:0];
  assign slice_cout = slice_out[4];

  always_comb begin
    // NOTE: every signal gets a hold-value default first so that no path
    // through the case statement leaves one unassigned (which would infer a latch).
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    s_hi_d   = s_hi_q;
    s_d      = s_q;
    d_d      = d_q;
    result_d = result_q;
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          m_d     = m;
          idx_d   = '0;
          carry_d = 1'b0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        s_d[4*idx_q +: 4] = slice_sum;
        carry_d           = slice_cout;
        idx_d             = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          s_hi_d  = slice_cout;
          idx_d   = '0;
          carry_d = 1'b1;             // the +1 of the two's complement of m
          state_d = S_SUB;
        end
      end
      S_SUB: begin
        d_d[4*idx_q +: 4] = slice_sum;
        carry_d           = slice_cout;
        idx_d             = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d    = '0;
          // {s_hi, s} >= m exactly when the W+1 bit sum carried out or
          // the W-bit subtraction produced no borrow.
          result_d = (s_hi_q | slice_cout) ? d_d : s_q;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: all state is updated with non-blocking assignments, so every flop
  // samples its _d value from before the clock edge, whatever the statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      s_hi_q   <= 1'b0;
      s_q      <= '0;
      d_q      <= '0;
      result_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      s_hi_q   <= s_hi_d;
      s_q      <= s_d;
      d_q      <= d_d;
      result_q <= result_d;
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
    end
  end

  // Handshake outputs come from state only, so they have no combinational path from inputs.
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_mod_add_serial.sv
// -----------------------------------------------------------------------------
// tb_mod_add_serial
//   Self-checking bench for mod_add_serial at W=16. It covers the reset state,
//   a table of directed vectors, backpressure, a mid-operation reset, and
//   randomized operands checked against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_mod_add_serial;

  localparam int W   = 16;
  localparam int N   = W / 4;
  localparam int LAT = 2 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b, m;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;

  int n_cmp  = 0;
  int n_fail = 0;

  mod_add_serial #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .m         (m),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] m;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: one conditional subtraction of m from the exact (W+1)-bit sum.
  function automatic logic [W-1:0] ref_mod_add(input logic [W-1:0] x,
                                               input logic [W-1:0] y,
                                               input logic [W-1:0] md);
    int unsigned s;
    s = x;
    s = s + y;
    if (s >= md) s = s - md;
    return s[W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents operands, waits for acceptance, then counts cycles until out_valid.
  // The operation is left in DONE. While it is busy, the inputs are scrambled
  // and in_valid is held high to show that both are ignored.
  task automatic start_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                          input logic [W-1:0] xm, output int lat);
    int  wait_cnt;
    bit  ready_leak;
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 50) begin
      tick();
      wait_cnt++;
    end
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a = xa;
    b = xb;
    m = xm;
    tick();                              // acceptance edge T
    a = W'($urandom);
    b = W'($urandom);
    m = W'($urandom);
    lat = 0;
    ready_leak = 1'b0;
    while (!out_valid && lat < 4 * LAT) begin
      if (in_ready) ready_leak = 1'b1;
      tick();
      lat++;
    end
    in_valid = 1'b0;
    check("in_ready_low_while_busy", 32'(ready_leak), 32'd0);
  endtask

  // Accepts the result and checks that the block is back in IDLE one cycle later.
  task automatic finish_op();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("out_valid_after_accept", 32'(out_valid), 32'd0);
    check("in_ready_after_accept", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int           lat;
    logic [W-1:0] ra, rb, rm, exp;

    vecs[0] = '{16'h1234, 16'h0100, 16'hFFF1, 16'h1334};  // no reduction
    vecs[1] = '{16'hFFF0, 16'h0005, 16'hFFF1, 16'h0004};  // sum >= m, no carry-out
    vecs[2] = '{16'hFFF0, 16'hFFF0, 16'hFFF1, 16'hFFEF};  // s_hi = 1
    vecs[3] = '{16'h8000, 16'h7FF1, 16'hFFF1, 16'h0000};  // sum == m
    vecs[4] = '{16'hFFFF, 16'h0002, 16'h0000, 16'h0001};  // m = 0 wraps mod 2^W
    vecs[5] = '{16'hFFFF, 16'hFFFF, 16'h0003, 16'hFFFB};  // precondition violated
    vecs[6] = '{16'h0000, 16'h0000, 16'h0001, 16'h0000};  // zeros
    vecs[7] = '{16'h0001, 16'h0001, 16'h0003, 16'h0002};  // small, sum < m

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    m = '0;
    tick();
    tick();
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    rst = 1'b0;
    tick();
    check("post_reset_in_ready", 32'(in_ready), 32'd1);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].m, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT));
      check($sformatf("vec%0d_result", i), 32'(result), 32'(vecs[i].exp));
      finish_op();
    end

    // Backpressure: the result stays stable while out_ready is low.
    start_op(16'h1234, 16'h0100, 16'hFFF1, lat);
    check("bp_latency", 32'(lat), 32'(LAT));
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_hold%0d_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("bp_hold%0d_result", k), 32'(result), 32'h1334);
      check($sformatf("bp_hold%0d_in_ready", k), 32'(in_ready), 32'd0);
      tick();
    end
    finish_op();

    // Abort: reset during the 3rd ADD cycle, then run a clean operation.
    in_valid = 1'b1;
    a = 16'hFFF0;
    b = 16'hFFF0;
    m = 16'hFFF1;
    tick();                              // accept
    in_valid = 1'b0;
    tick();
    tick();                              // now in the 3rd ADD cycle
    rst = 1'b1;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    start_op(16'hFFF0, 16'h0005, 16'hFFF1, lat);
    check("post_abort_latency", 32'(lat), 32'(LAT));
    check("post_abort_result", 32'(result), 32'h0004);
    finish_op();

    // Randomized operands against the reference model
    for (int i = 0; i < 40; i++) begin
      if (i % 4 == 3) begin
        ra = W'($urandom);
        rb = W'($urandom);
        rm = W'($urandom);
      end else begin
        rm = W'($urandom_range(1, 32'hFFFF));
        ra = W'($urandom_range(0, 32'(rm) - 1));
        rb = W'($urandom_range(0, 32'(rm) - 1));
      end
      exp = ref_mod_add(ra, rb, rm);
      start_op(ra, rb, rm, lat);
      check($sformatf("rand%0d_latency", i), 32'(lat), 32'(LAT));
      if (result !== exp) $display("  operands a=%h b=%h m=%h", ra, rb, rm);
      check($sformatf("rand%0d_result", i), 32'(result), 32'(exp));
      finish_op();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mod_add_serial.md
# mod_add_serial

Nibble-serial modular adder that computes (a + b) mod m for W-bit operands using a single CLA_ADD_4 slice reused every cycle. It sits in the modular-division datapath as the reduction-add stage. It is the driver and consumer of the 4-bit carry-lookahead slice: it feeds the slice one operand nibble per cycle and stores the returned sum nibble and carry. Input and output use valid/ready handshakes; one operation is in flight at a time.

## Interface
- W, 256, operand width in bits; must be a multiple of 4 and ≥ 8; N = W/4 nibbles
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operand set a/b/m valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  W  addend, intended a < m
- b  input  W  addend, intended b < m
- m  input  W  modulus
- out_valid  output  1  result valid (high only in DONE)
- out_ready  input  1  downstream accepts result
- result  output  W  (a + b) mod m, held stable while out_valid=1

## Operation
- One CLA_ADD_4 instance; its operand muxes select nibble idx of the working registers; carry register feeds c_in.
- States: IDLE, ADD, SUB, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture a, b, m into internal registers; idx=0; carry=0; go to ADD.
- ADD, one cycle per nibble:
  - s[4idx+3:4idx] ← sum(a_nib, b_nib, carry); carry ← c_out; idx++.
  - At idx=N-1: s_hi ← c_out; idx ← 0; carry ← 1; go to SUB.
- SUB, one cycle per nibble:
  - d[4idx+3:4idx] ← sum(s_nib, ~m_nib, carry); carry ← c_out; idx++.
  - At idx=N-1: no_borrow = s_hi | c_out; result ← no_borrow ? d : s; go to DONE.
- DONE:
  - out_valid=1; result held.
  - On out_ready: go to IDLE. in_ready rises the following cycle; there is no same-cycle accept.
- Arithmetic:
  - Exactly one conditional subtraction of m from the (W+1)-bit sum {s_hi, s}.
  - If a, b < m: result = (a+b) mod m exactly.
  - If the precondition is violated: result = a+b−m when a+b ≥ m, else a+b, truncated to W bits. No error flag.
  - m=0: no_borrow=1, result = (a+b) mod 2^W.
- Operand registers are not reloaded outside IDLE; input changes during ADD/SUB/DONE have no effect.
- in_valid while not in IDLE is ignored. The upstream block must hold in_valid until in_ready.

## Timing
- Reset: state=IDLE, idx=0, carry=0, s_hi=0, and s, d, result, operand registers = 0. in_ready=1 and out_valid=0 while and after rst is high.
- Reset asserted mid-operation aborts immediately. No partial result is ever presented.
- Latency: operands accepted at edge T. ADD occupies edges T+1..T+N and SUB occupies edges T+N+1..T+2N. out_valid is high from the cycle after edge T+2N.
  - Total 2N cycles from acceptance; 8 for W=16, 128 for W=256.
- Throughput: one result per 2N+2 cycles at best (accept cycle + 2N + DONE cycle with out_ready=1).
- out_valid and result do not change while out_valid=1 and out_ready=0.
- Every output is registered or decoded from state only. No combinational path from in_valid/out_ready to in_ready/out_valid.

## Test plan
Use W=16, m=0xFFF1 unless stated.
1. a=0x1234, b=0x0100 → out_valid exactly 8 cycles after accept, result=0x1334 (no reduction).
2. a=0xFFF0, b=0x0005 → result=0x0004 (sum ≥ m, no W-bit carry-out).
3. a=0xFFF0, b=0xFFF0 → result=0xFFEF (s_hi=1 path).
4. a=0x8000, b=0x7FF1 → result=0x0000 (sum equals m exactly).
5. Backpressure: complete case 1, hold out_ready=0 for 5 cycles → out_valid=1 and result=0x1334 stable, in_ready=0 throughout. Raise out_ready → next cycle out_valid=0 and in_ready=1.
6. Abort: accept case 3, assert rst at the 3rd ADD cycle → in_ready=1 and out_valid=0 immediately. Then run case 2 → result=0x0004 with no contamination.
